// File: rtl/turn_lever_ctrl.sv
// rtl/turn_lever_ctrl.sv - turn lever conditioning, direction latch, tick strobe and auto-cancel
module turn_lever_ctrl #(
    parameter int DEBOUNCE     = 16,
    parameter int TICK_DIV     = 1000,
    parameter int CANCEL_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lever_l,
    input  logic       lever_r,
    input  logic       cancel,
    output logic [1:0] dir,
    output logic       tick,
    output logic       active
);

    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int TW  = $clog2(TICK_DIV);
    localparam int ACW = $clog2(CANCEL_TICKS + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [TW-1:0]  TD_LAST = TW'(TICK_DIV - 1);
    localparam logic [ACW-1:0] AC_LAST = ACW'(CANCEL_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b11
    } state_t;

    state_t state, state_n;

    logic l_s1, l_s2, r_s1, r_s2, c_s1, c_s2;
    logic db_l, db_r, db_l_d, db_r_d;
    logic [DBW-1:0] cnt_l, cnt_r;
    logic [TW-1:0]  tcnt;
    logic [ACW-1:0] acnt;
    logic press_l, press_r, auto_cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            {l_s1, l_s2, r_s1, r_s2, c_s1, c_s2} <= '0;
        end else begin
            l_s1 <= lever_l;
            l_s2 <= l_s1;
            r_s1 <= lever_r;
            r_s2 <= r_s1;
            c_s1 <= cancel;
            c_s2 <= c_s1;
        end
    end

    // A new level must survive DEBOUNCE consecutive clocks; any return restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_l  <= 1'b0;
            db_r  <= 1'b0;
            cnt_l <= '0;
            cnt_r <= '0;
        end else begin
            if (l_s2 == db_l) begin
                cnt_l <= '0;
            end else if (cnt_l == DB_LAST) begin
                db_l  <= l_s2;
                cnt_l <= '0;
            end else begin
                cnt_l <= cnt_l + 1'b1;
            end
            if (r_s2 == db_r) begin
                cnt_r <= '0;
            end else if (cnt_r == DB_LAST) begin
                db_r  <= r_s2;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_l_d <= 1'b0;
            db_r_d <= 1'b0;
        end else begin
            db_l_d <= db_l;
            db_r_d <= db_r;
        end
    end

    assign press_l = db_l & ~db_l_d;
    assign press_r = db_r & ~db_r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tcnt == TD_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tick = (tcnt == TD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        auto_cancel = (state != IDLE) && tick && (acnt == AC_LAST);
        if (c_s2) begin
            state_n = IDLE;
        end else if (auto_cancel) begin
            state_n = IDLE;
        end else if (press_l && !press_r) begin
            state_n = (state == LEFT) ? IDLE : LEFT;
        end else if (press_r && !press_l) begin
            state_n = (state == RIGHT) ? IDLE : RIGHT;
        end
    end

    // Restart the tick budget on every entry into a direction, including LEFT<->RIGHT.
    always_ff @(posedge clk) begin
        if (rst) begin
            acnt <= '0;
        end else if (state_n == IDLE || state_n != state) begin
            acnt <= '0;
        end else if (tick) begin
            acnt <= acnt + 1'b1;
        end
    end

    assign dir    = state;
    assign active = (state != IDLE);

endmodule

// File: tb/tb_turn_lever_ctrl.sv
// tb/tb_turn_lever_ctrl.sv - scoreboard bench for turn_lever_ctrl against a behavioural model
module tb_turn_lever_ctrl;

    localparam int DB = 4;
    localparam int TD = 8;
    localparam int CT = 6;

    logic       clk;
    logic       rst;
    logic       lever_l;
    logic       lever_r;
    logic       cancel;
    logic [1:0] dir;
    logic       tick;
    logic       active;

    turn_lever_ctrl #(.DEBOUNCE(DB), .TICK_DIV(TD), .CANCEL_TICKS(CT)) dut (
        .clk(clk), .rst(rst), .lever_l(lever_l), .lever_r(lever_r),
        .cancel(cancel), .dir(dir), .tick(tick), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    // model state: 0 idle, 1 right, 2 left
    int m_l1, m_l2, m_r1, m_r2, m_c1, m_c2;
    int db_l, db_r, dbd_l, dbd_r, run_l, run_r;
    int st, tseen, cyc;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic deb(input int v, inout int acc, inout int run);
        if (v == acc) begin
            run = 0;
        end else begin
            run++;
            if (run == DB) begin
                acc = v;
                run = 0;
            end
        end
    endtask

    task automatic model_step(input int l, input int r, input int c, input int rs);
        int pl, pr, tk, nx;
        logic [1:0] d;
        if (rs != 0) begin
            m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0; m_c1 = 0; m_c2 = 0;
            db_l = 0; db_r = 0; dbd_l = 0; dbd_r = 0; run_l = 0; run_r = 0;
            st = 0; tseen = 0; cyc = 0;
        end else begin
            pl = (db_l == 1 && dbd_l == 0) ? 1 : 0;
            pr = (db_r == 1 && dbd_r == 0) ? 1 : 0;
            tk = ((cyc % TD) == TD - 1) ? 1 : 0;
            nx = st;
            if (m_c2 != 0) nx = 0;
            else if (st != 0 && tk != 0 && tseen + 1 == CT) nx = 0;
            else if (pl != 0 && pr == 0) nx = (st == 2) ? 0 : 2;
            else if (pr != 0 && pl == 0) nx = (st == 1) ? 0 : 1;
            if (nx == 0 || nx != st) tseen = 0;
            else if (tk != 0) tseen++;
            st = nx;
            dbd_l = db_l;
            dbd_r = db_r;
            deb(m_l2, db_l, run_l);
            deb(m_r2, db_r, run_r);
            m_l2 = m_l1; m_l1 = l;
            m_r2 = m_r1; m_r1 = r;
            m_c2 = m_c1; m_c1 = c;
            cyc++;
        end
        d = (st == 0) ? 2'b00 : (st == 1) ? 2'b01 : 2'b11;
        exp_q.push_back({d, (st != 0), ((cyc % TD) == TD - 1)});
    endtask

    task automatic cycle(input int l, input int r, input int c, input int rs);
        lever_l = l[0];
        lever_r = r[0];
        cancel  = c[0];
        rst     = rs[0];
        @(posedge clk);
        #1;
        model_step(l, r, c, rs);
    endtask

    task automatic hold(input int l, input int r, input int n);
        for (int i = 0; i < n; i++) cycle(l, r, 0, 0);
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({dir, active, tick} != e) begin
                    n_bad++;
                    $display("FAIL out @%0t: dir=%b active=%b tick=%b expected dir=%b active=%b tick=%b",
                             $time, dir, active, tick, e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : stim
        int cnt, idx, last, len, l, r;
        lever_l = 1'b0; lever_r = 1'b0; cancel = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        hold(0, 0, 2);

        // clean right press: latency DEBOUNCE+3 edges from the first sampling edge
        cnt = 0;
        while (cnt < 20) begin
            cycle(0, 1, 0, 0);
            cnt++;
            if (dir == 2'b01) break;
        end
        chk("press_latency", cnt, DB + 3);
        hold(0, 1, 20 - cnt);
        hold(0, 0, 10);
        chk("dir_after_release", int'(dir), 1);

        // toggle off, then bounce rejection
        hold(0, 1, 8); hold(0, 0, 8);
        chk("toggle_off_r", int'(dir), 0);
        for (int k = 0; k < 2; k++) begin
            hold(0, 1, 2); hold(0, 0, 2);
        end
        hold(0, 0, 6);
        chk("bounce_rejected", int'(dir), 0);
        hold(0, 1, 10);
        chk("press_after_bounce", int'(dir), 1);
        hold(0, 0, 8);

        // direction switch and toggle-off of left
        hold(1, 0, 8); hold(0, 0, 4);
        chk("switch_to_left", int'(dir), 3);
        hold(1, 0, 8); hold(0, 0, 4);
        chk("toggle_off_l", int'(dir), 0);

        // auto-cancel with exact tick period
        hold(1, 0, 8); hold(0, 0, 2);
        chk("enter_left", int'(dir), 3);
        last = -1; idx = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(0, 0, 0, 0);
            idx++;
            if (tick) begin
                if (last >= 0) chk("tick_period", idx - last, TD);
                last = idx;
            end
        end
        chk("auto_cancelled", int'(dir), 0);

        // simultaneous press, then cancel pulse
        hold(1, 1, 10); hold(0, 0, 8);
        chk("both_pressed", int'(dir), 0);
        hold(0, 1, 8);
        chk("enter_right", int'(dir), 1);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 0, 0);
        chk("cancel_not_yet", int'(dir), 1);
        cycle(0, 1, 0, 0);
        chk("cancel_e3", int'(dir), 0);
        hold(0, 0, 8);

        // reset mid-operation
        hold(1, 0, 8); hold(0, 0, 3);
        cycle(1, 0, 0, 1);
        chk("rst_dir", int'(dir), 0);
        chk("rst_tick", int'(tick), 0);
        hold(0, 0, 12);

        // randomized segments
        for (int seg = 0; seg < 300; seg++) begin
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 70)) : int'($urandom_range(1, 10));
            l = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r = ($urandom_range(0, 2) == 0) ? 1 : 0;
            for (int k = 0; k < len; k++)
                cycle(l, r, ($urandom_range(0, 29) == 0) ? 1 : 0, ($urandom_range(0, 499) == 0) ? 1 : 0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/turn_lever_ctrl.md
# turn_lever_ctrl

Upstream driver for the turn-signal sequencer. It conditions the raw left/right lever switches and the steering-return cancel input, and latches the selected direction as a two-bit `dir` code. It generates a periodic `tick` strobe and auto-cancels the signal after a programmable number of ticks. `dir` connects directly to the sequencer's `dir` input; `tick` is available as a clock-enable for the lamp pacing logic.

## Interface
- `DEBOUNCE`, 16: clocks a synchronized input must hold a new level before it is accepted (≥1).
- `TICK_DIV`, 1000: clocks per `tick` period (≥2).
- `CANCEL_TICKS`, 30: ticks spent in LEFT/RIGHT before automatic return to IDLE (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `lever_l`  in  1  raw left lever contact, asynchronous, bouncy, active-high.
- `lever_r`  in  1  raw right lever contact, asynchronous, bouncy, active-high.
- `cancel`  in  1  steering-return contact, asynchronous, active-high, not debounced.
- `dir`  out  2  00 straight, 01 right, 11 left; 10 is never driven.
- `tick`  out  1  one-clock strobe every `TICK_DIV` clocks.
- `active`  out  1  high in LEFT or RIGHT.

## Operation
- **Synchronizers:** each of `lever_l`, `lever_r` and `cancel` passes through a 2-flop synchronizer. Reset value of all synchronizer flops is 0.
- **Debounce (per lever, independent):**
  - State: accepted level `db` and a counter of width $clog2(DEBOUNCE+1).
  - If synced level equals `db`: counter clears to 0.
  - Otherwise the counter increments. When the counter is at DEBOUNCE-1 with the level still different, `db` takes the new level and the counter clears.
  - Reset: `db`=0, counter=0.
- **Press detect:** `press_x` = `db_x` & ~`db_x` delayed one clock. Releases generate no event.
- **FSM states:** IDLE, RIGHT, LEFT. Reset state is IDLE. Priority per clock is: rst > synced `cancel` > auto-cancel > presses.
- **Transitions:**
  - IDLE: `press_r` only -> RIGHT; `press_l` only -> LEFT.
  - RIGHT: `press_r` -> IDLE (toggle off); `press_l` -> LEFT.
  - LEFT: `press_l` -> IDLE; `press_r` -> RIGHT.
  - `press_l` and `press_r` in the same clock: no state change.
  - Synced `cancel` high in LEFT or RIGHT: -> IDLE. It is level-sensitive, so presses are ignored while it is held.
- **Auto-cancel:**
  - A tick counter with width to hold CANCEL_TICKS clears on every entry into LEFT or RIGHT, including a direct LEFT<->RIGHT switch.
  - It increments on each `tick` while `active`.
  - On the `tick` where counter = CANCEL_TICKS-1, the state goes to IDLE and the counter clears.
- **Tick generator:**
  - Free-running counter 0..TICK_DIV-1, wrapping to 0; reset value 0.
  - `tick`=1 when counter = TICK_DIV-1. It is independent of FSM state.
- **Outputs:** `dir` and `active` decode directly from the state register: IDLE=00, RIGHT=01, LEFT=11.
- **Reset values:** `dir`=00, `tick`=0, `active`=0, with all counters cleared.

## Timing
- A lever level that is stable before clock edge E1 appears at the synchronizer output at E2 and at `db` at E2+DEBOUNCE.
- `dir` changes at E3+DEBOUNCE, so press-to-`dir` latency is DEBOUNCE+3 clocks.
- A bounce shorter than DEBOUNCE clocks at the synchronizer output restarts the counter and produces no press.
- `cancel` high before E1 forces IDLE at E3 (2-clock sync plus 1 state update).
- First `tick` after reset occurs in clock TICK_DIV (counter value TICK_DIV-1). After that, `tick` pulses every TICK_DIV clocks with no jitter.
- With LEFT/RIGHT entered at edge S, auto-cancel IDLE occurs on the edge following the CANCEL_TICKS-th `tick` after S.
- `rst` asserted mid-operation: all outputs return to reset values at the next edge, and any in-progress debounce is discarded.

## Test plan
Parameters for all scenarios: DEBOUNCE=4, TICK_DIV=8, CANCEL_TICKS=6.

1. **Clean right press:** hold `lever_r` high 20 clocks -> `dir`=01 and `active`=1 exactly 7 clocks after the first sampling edge. Releasing the lever leaves `dir`=01.
2. **Bounce rejection:** toggle `lever_r` 1,0,1,0 with 2-clock pulses -> `dir` stays 00. Then hold high 10 clocks -> `dir`=01.
3. **Direction switch and toggle-off:** in RIGHT, press `lever_l` -> `dir`=11. Press `lever_l` again -> `dir`=00.
4. **Auto-cancel:** enter LEFT, no further input -> `dir`=11 for 6 ticks, then returns to 00 on the edge after the 6th `tick` (about 48 clocks). `tick` is measured at an exact period of 8 throughout.
5. **Cancel and simultaneous press:** both levers pressed together in IDLE -> `dir`=00. In RIGHT, pulse `cancel` for 1 clock -> `dir`=00 two clocks after that clock's edge (E3).
6. **Reset mid-operation:** assert `rst` while `dir`=11 and the tick counter is mid-count -> next edge gives `dir`=00, `active`=0, `tick`=0. The next `tick` occurs 8 clocks after `rst` deasserts.
